// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// default starvation limit and the core halt-bit map.
package data_bus_arbiter_pkg;

  // Arbiter FSM states; the encoding values are fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  // Consecutive blocked cycles before the arbiter asks the core to halt.
  localparam int DEFAULT_WAIT_LIMIT = 8;

  // Core halt-request bit positions; the arbiter owns HALT_ARB.
  localparam int HALT_DBG  = 0;
  localparam int HALT_BKPT = 1;
  localparam int HALT_ARB  = 2;
  localparam int HALT_BITS = 3;

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating wait counter with synchronous clear and a registered
// terminal flag. The flag rises the cycle after the count has reached
// LIMIT and drops the cycle after a clear.
module arb_wait_ctr #(
  parameter int LIMIT = 8,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

  logic [CW-1:0] count;

  // Count blocked cycles up to LIMIT and flag the saturated value one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (!reset_n) begin
      count    <= '0;
      at_limit <= 1'b0;
    end else begin
      if (clr) begin
        count <= '0;
      end else if (inc && (count != LIMIT_V)) begin
        count <= count + CW'(1);
      end
      at_limit <= !clr && (count == LIMIT_V);
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Data-memory port arbiter. The core load/store path has absolute
// priority and is routed combinationally; a secondary master (loader,
// debugger, DMA) is served through a req/ack handshake in cycles where
// the core is not strobing.
// Optional feature: define DATA_ARB_HALT_EN to build the starvation
// counter that drives halt_req; otherwise halt_req is tied low.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter  int WAIT_LIMIT = DEFAULT_WAIT_LIMIT,
  localparam int CW         = $clog2(WAIT_LIMIT + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        c_strobe,
  input  logic        c_rw,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  input  logic        p1_req,
  input  logic        p1_rw,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        m_strobe,
  output logic        m_rw,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        halt_req,
  output logic        busy
);

  arb_state_t state;
  logic       grant;

  // The secondary master is only served when the core leaves the port idle
  // and the previous secondary access has finished its ack cycle.
  assign grant = p1_req && !c_strobe && (state != ACK);

  // Core load data is never registered.
  assign c_rdata = m_rdata;
  assign p1_ack  = (state == ACK);
  assign busy    = p1_req || (state == ACK);

  // Memory-port mux: core first, then a granted secondary access, else idle.
  always_comb begin
    // NOTE: every output gets a default before the branches so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    m_strobe = 1'b0;
    m_rw     = 1'b0;
    m_addr   = c_addr;
    m_wdata  = c_wdata;
    if (c_strobe) begin
      m_strobe = 1'b1;
      m_rw     = c_rw;
    end else if (grant) begin
      m_strobe = 1'b1;
      m_rw     = p1_rw;
      m_addr   = p1_addr;
      m_wdata  = p1_wdata;
    end
  end

  // Handshake FSM; captures secondary load data on the granted cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      p1_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= ACK;
            if (!p1_rw) p1_rdata <= m_rdata;
          end else if (p1_req && c_strobe) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (grant) begin
            state <= ACK;
            if (!p1_rw) p1_rdata <= m_rdata;
          end else if (!p1_req) begin
            // Master withdrew its request without an ack.
            state <= IDLE;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DATA_ARB_HALT_EN
  logic blocked;
  logic wait_clr;

  // A blocked cycle is a pending request losing to a core strobe outside ACK.
  assign blocked  = p1_req && c_strobe && (state != ACK);
  assign wait_clr = grant || !p1_req;

  arb_wait_ctr #(
    .LIMIT (WAIT_LIMIT),
    .CW    (CW)
  ) u_wait_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (blocked),
    .clr      (wait_clr),
    .at_limit (halt_req)
  );
`else
  // Without the counter the secondary master relies on natural core idle cycles.
  assign halt_req = 1'b0;
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: a directed vector table,
// hand-written halt and reset sequences, and randomized traffic checked
// every cycle against a behavioural model of the arbitration rules.
module tb_data_bus_arbiter;

  localparam int LIMIT = 8;
`ifdef DATA_ARB_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        c_strobe, c_rw;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        p1_req, p1_rw;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_ack;
  logic [31:0] p1_rdata;
  logic        m_strobe, m_rw;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        halt_req, busy;

  int checks = 0;
  int errors = 0;

  data_bus_arbiter #(.WAIT_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .c_strobe (c_strobe),
    .c_rw     (c_rw),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_rdata  (c_rdata),
    .p1_req   (p1_req),
    .p1_rw    (p1_rw),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_ack   (p1_ack),
    .p1_rdata (p1_rdata),
    .m_strobe (m_strobe),
    .m_rw     (m_rw),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .halt_req (halt_req),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Data RAM seen by the DUT: combinational read, write on the clock edge.
  logic [31:0] mem [256];
  assign m_rdata = mem[m_addr[9:2]];
  always @(posedge clk) if (m_strobe && m_rw) mem[m_addr[9:2]] <= m_wdata;

  // Reference memory, updated only from the model's expected writes.
  logic [31:0] ref_mem [256];

  // Behavioural model: is this an ack cycle, held load data, blocked-cycle
  // count and the halt request visible this cycle.
  bit          md_ack,  nx_ack;
  logic [31:0] md_rdata, nx_rdata;
  int          md_blk,  nx_blk;
  bit          md_halt, nx_halt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    md_ack = 0; md_rdata = '0; md_blk = 0; md_halt = 0;
  endtask

  task automatic drive(input logic cs, input logic crw, input logic [31:0] ca, input logic [31:0] cw,
                       input logic rq, input logic prw, input logic [31:0] pa, input logic [31:0] pw);
    c_strobe = cs; c_rw = crw; c_addr = ca; c_wdata = cw;
    p1_req = rq; p1_rw = prw; p1_addr = pa; p1_wdata = pw;
  endtask

  // Compare all outputs against the model mid-cycle and work out the model's next cycle.
  task automatic sample();
    bit          grant;
    logic        e_strobe, e_rw;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    grant = p1_req && !c_strobe && !md_ack;
    if (c_strobe) begin
      e_strobe = 1; e_rw = c_rw; e_addr = c_addr; e_wdata = c_wdata;
    end else if (grant) begin
      e_strobe = 1; e_rw = p1_rw; e_addr = p1_addr; e_wdata = p1_wdata;
    end else begin
      e_strobe = 0; e_rw = 0; e_addr = c_addr; e_wdata = c_wdata;
    end
    check("m_strobe", m_strobe, e_strobe);
    check("m_rw",     m_rw,     e_rw);
    check("m_addr",   m_addr,   e_addr);
    check("m_wdata",  m_wdata,  e_wdata);
    check("c_rdata",  c_rdata,  ref_mem[e_addr[9:2]]);
    check("p1_ack",   p1_ack,   md_ack);
    check("busy",     busy,     p1_req || md_ack);
    check("p1_rdata", p1_rdata, md_rdata);
    check("halt_req", halt_req, HALT_EN && md_halt);
    nx_rdata = md_rdata;
    if (grant && !p1_rw) nx_rdata = ref_mem[p1_addr[9:2]];
    if (e_strobe && e_rw) ref_mem[e_addr[9:2]] = e_wdata;
    nx_ack  = grant;
    nx_halt = (md_blk == LIMIT) && !(grant || !p1_req);
    if (grant || !p1_req)       nx_blk = 0;
    else if (c_strobe && !md_ack) nx_blk = (md_blk + 1 > LIMIT) ? LIMIT : md_blk + 1;
    else                        nx_blk = md_blk;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    md_ack = nx_ack; md_rdata = nx_rdata; md_blk = nx_blk; md_halt = nx_halt;
  endtask

  typedef struct {
    logic        cs, crw;
    logic [31:0] ca, cw;
    logic        rq, prw;
    logic [31:0] pa, pw;
    logic        e_strobe, e_rw;
    logic [31:0] e_addr, e_wdata;
    logic        e_ack, e_busy;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic cs, logic crw, logic [31:0] ca, logic [31:0] cw,
                              logic rq, logic prw, logic [31:0] pa, logic [31:0] pw,
                              logic es, logic erw, logic [31:0] ea, logic [31:0] ew,
                              logic eack, logic ebusy, logic [31:0] erd);
    vec_t v;
    v.cs = cs; v.crw = crw; v.ca = ca; v.cw = cw;
    v.rq = rq; v.prw = prw; v.pa = pa; v.pw = pw;
    v.e_strobe = es; v.e_rw = erw; v.e_addr = ea; v.e_wdata = ew;
    v.e_ack = eack; v.e_busy = ebusy; v.e_rdata = erd;
    return v;
  endfunction

  // Mid-cycle asynchronous reset with inputs parked idle; the request is abandoned.
  task automatic async_reset_check(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    check({tag, "_p1_ack"},   p1_ack,   1'b0);
    check({tag, "_halt_req"}, halt_req, 1'b0);
    check({tag, "_p1_rdata"}, p1_rdata, 32'h0);
    check({tag, "_busy"},     busy,     1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      sample();
      check($sformatf("%s_no_ack_%0d", tag, i), p1_ack, 1'b0);
      advance();
    end
  endtask

  initial begin
    logic [31:0] dbeef = 32'hDEAD_BEEF;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hC0DE_0000 | 32'(i);
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    mem[64]     = dbeef;
    ref_mem[64] = dbeef;

    vecs[0]  = mk(0,0,0,0,            1,0,32'h100,0,            1,0,32'h100,0,            0,1,0);
    vecs[1]  = mk(0,0,0,0,            0,0,0,0,                  0,0,0,0,                  1,1,dbeef);
    vecs[2]  = mk(0,0,0,0,            0,0,0,0,                  0,0,0,0,                  0,0,dbeef);
    vecs[3]  = mk(1,1,32'h20,32'h1111_2222, 1,1,32'h30,32'h3333_4444, 1,1,32'h20,32'h1111_2222, 0,1,dbeef);
    vecs[4]  = mk(0,0,0,0,            1,1,32'h30,32'h3333_4444, 1,1,32'h30,32'h3333_4444, 0,1,dbeef);
    vecs[5]  = mk(0,0,0,0,            0,0,0,0,                  0,0,0,0,                  1,1,dbeef);
    vecs[6]  = mk(0,0,0,0,            0,0,0,0,                  0,0,0,0,                  0,0,dbeef);
    for (int i = 7; i <= 14; i++) begin
      if (i % 2 == 1)
        vecs[i] = mk(0,0,0,0, 1,0,32'h20,0, 1,0,32'h20,0, 0,1, (i == 7) ? dbeef : 32'h1111_2222);
      else
        vecs[i] = mk(0,0,0,0, 1,0,32'h20,0, 0,0,0,0,      1,1, 32'h1111_2222);
    end
    vecs[15] = mk(0,0,0,0,            1,0,32'h30,0,             1,0,32'h30,0,             0,1,32'h1111_2222);
    vecs[16] = mk(0,0,0,0,            0,0,0,0,                  0,0,0,0,                  1,1,32'h3333_4444);
    vecs[17] = mk(0,0,0,0,            0,0,0,0,                  0,0,0,0,                  0,0,32'h3333_4444);

    // Reset state.
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_p1_ack",   p1_ack,   1'b0);
    check("rst_halt_req", halt_req, 1'b0);
    check("rst_p1_rdata", p1_rdata, 32'h0);
    check("rst_busy",     busy,     1'b0);
    check("rst_m_strobe", m_strobe, 1'b0);
    reset_n = 1'b1;

    // Directed vectors: minimum latency, core-wins collision, back-to-back requests.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].cs, vecs[i].crw, vecs[i].ca, vecs[i].cw,
            vecs[i].rq, vecs[i].prw, vecs[i].pa, vecs[i].pw);
      sample();
      check($sformatf("vec%0d_m_strobe", i), m_strobe, vecs[i].e_strobe);
      check($sformatf("vec%0d_m_rw", i),     m_rw,     vecs[i].e_rw);
      check($sformatf("vec%0d_m_addr", i),   m_addr,   vecs[i].e_addr);
      check($sformatf("vec%0d_m_wdata", i),  m_wdata,  vecs[i].e_wdata);
      check($sformatf("vec%0d_p1_ack", i),   p1_ack,   vecs[i].e_ack);
      check($sformatf("vec%0d_busy", i),     busy,     vecs[i].e_busy);
      check($sformatf("vec%0d_p1_rdata", i), p1_rdata, vecs[i].e_rdata);
      advance();
    end

    // Starvation: core strobes 12 cycles while a read waits.
    drive(1, 0, 0, 0, 1, 0, 32'h100, 0);
    for (int k = 0; k < 12; k++) begin
      sample();
      check($sformatf("starve%0d_halt_req", k), halt_req, HALT_EN && (k >= 9));
      check($sformatf("starve%0d_p1_ack", k),   p1_ack,   1'b0);
      advance();
    end
    drive(0, 0, 0, 0, 1, 0, 32'h100, 0);
    sample();
    check("starve_grant_m_addr",   m_addr,   32'h100);
    check("starve_grant_halt_req", halt_req, HALT_EN);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    check("starve_ack_p1_ack",   p1_ack,   1'b1);
    check("starve_ack_halt_req", halt_req, 1'b0);
    check("starve_ack_p1_rdata", p1_rdata, dbeef);
    advance();

    // Asynchronous reset while acking.
    drive(0, 0, 0, 0, 1, 0, 32'h30, 0);
    sample();
    advance();
    check("pre_reset_ack", p1_ack, 1'b1);
    async_reset_check("rst_in_ack");

    // Asynchronous reset while waiting (halt already raised when enabled).
    drive(1, 0, 0, 0, 1, 0, 32'h100, 0);
    repeat (10) begin
      sample();
      advance();
    end
    check("pre_reset_halt", halt_req, HALT_EN);
    async_reset_check("rst_in_wait");

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit          hot = ((cyc / 40) % 2) == 1;
      logic        cs  = hot ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 2) == 0);
      logic        rq  = p1_req;
      logic        prw = p1_rw;
      logic [31:0] pa  = p1_addr;
      logic [31:0] pw  = p1_wdata;
      bit          fresh = 0;
      if (md_ack)           begin rq = $urandom_range(0, 1); fresh = rq; end
      else if (!rq)         begin rq = ($urandom_range(0, 2) == 0); fresh = rq; end
      else if ($urandom_range(0, 31) == 0) rq = 0;
      if (fresh) begin
        prw = $urandom_range(0, 1);
        pa  = 32'($urandom_range(0, 255)) << 2;
        pw  = $urandom;
      end
      drive(cs, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, $urandom,
            rq, prw, pa, pw);
      sample();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
